mdu_arbiter: RTL



---
 rtl/mdu_arbiter.sv | 139 +++++++++++++
 1 files changed

// File: rtl/mdu_arbiter.sv
// mdu_arbiter: shares one multi-cycle MDU between NUM_REQ requesters.
// A round-robin pick in IDLE latches the winner's op/operands, pulses the
// MDU once, waits for its ready level, then returns the result to the owner.
// Only one operation is ever in flight.
module mdu_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid_i,
  input  logic [3*NUM_REQ-1:0]    req_op_i,
  input  logic [32*NUM_REQ-1:0]   req_rs1_i,
  input  logic [32*NUM_REQ-1:0]   req_rs2_i,
  input  logic [NUM_REQ-1:0]      req_kill_i,
  output logic [NUM_REQ-1:0]      req_ready_o,
  output logic [NUM_REQ-1:0]      resp_valid_o,
  output logic [31:0]             resp_data_o,
  output logic                    busy_o,
  output logic                    mdu_valid_o,
  output logic [2:0]              mdu_op_o,
  output logic [31:0]             mdu_rs1_o,
  output logic [31:0]             mdu_rs2_o,
  input  logic                    mdu_ready_i,
  input  logic [31:0]             mdu_rd_i
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t              state, state_n;
  logic [PW-1:0]       rr_ptr;
  logic [PW-1:0]       owner;
  logic                killed;
  logic [31:0]         result;

  logic [NUM_REQ-1:0]  eligible;
  logic                gnt_found;
  logic [PW-1:0]       gnt_idx;
  logic [PW-1:0]       gnt_next;
  logic [NUM_REQ-1:0]  gnt_oh;
  logic [NUM_REQ-1:0]  resp_oh;

  // Round-robin search: first eligible index at or after rr_ptr, wrapping.
  always_comb begin
    int          cand;
    logic [PW-1:0] cand_idx;
    eligible  = req_valid_i & ~req_kill_i;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = int'(rr_ptr) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      cand_idx = PW'(cand);
      if (!gnt_found && eligible[cand_idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand_idx;
      end
    end
    gnt_next = (gnt_idx == PW'(NUM_REQ - 1)) ? '0 : gnt_idx + PW'(1);
  end

  // Next-state and strobe decode; ready is gated by reset so nothing is
  // ever acknowledged on a cycle that will be discarded.
  always_comb begin
    state_n = state;
    gnt_oh  = '0;
    resp_oh = '0;
    case (state)
      IDLE: begin
        if (gnt_found) begin
          state_n = ISSUE;
          if (!rst) gnt_oh[gnt_idx] = 1'b1;
        end
      end
      ISSUE: state_n = WAIT;
      WAIT:  if (mdu_ready_i) state_n = RESP;
      RESP: begin
        state_n = IDLE;
        if (!killed && !req_kill_i[owner]) resp_oh[owner] = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  assign req_ready_o  = gnt_oh;
  assign resp_valid_o = resp_oh;
  assign resp_data_o  = (|resp_oh) ? result : 32'd0;
  assign busy_o       = (state != IDLE);
  assign mdu_valid_o  = (state == ISSUE);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Grant bookkeeping, operand capture, kill tracking and result capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr    <= '0;
      owner     <= '0;
      killed    <= 1'b0;
      result    <= '0;
      mdu_op_o  <= '0;
      mdu_rs1_o <= '0;
      mdu_rs2_o <= '0;
    end else begin
      if (state == IDLE && gnt_found) begin
        owner     <= gnt_idx;
        rr_ptr    <= gnt_next;
        killed    <= 1'b0;
        mdu_op_o  <= req_op_i[3*int'(gnt_idx) +: 3];
        mdu_rs1_o <= req_rs1_i[32*int'(gnt_idx) +: 32];
        mdu_rs2_o <= req_rs2_i[32*int'(gnt_idx) +: 32];
      end
      // The MDU op cannot be cancelled, so a flush only suppresses delivery.
      if ((state == ISSUE || state == WAIT) && req_kill_i[owner])
        killed <= 1'b1;
      if (state == WAIT && mdu_ready_i)
        result <= mdu_rd_i;
    end
  end

  a_ready_onehot: assert property (@(posedge clk) disable iff (rst)
    $onehot0(req_ready_o));
  a_resp_onehot: assert property (@(posedge clk) disable iff (rst)
    $onehot0(resp_valid_o));
  a_no_ready_busy: assert property (@(posedge clk) disable iff (rst)
    busy_o |-> (req_ready_o == '0));

endmodule
